// File: rtl/board_update_arbiter.sv
// Board write arbiter: round-robin A/B cell writes gated to vertical blanking,
// plus a full-board clear sweep triggered by new_game.
module board_update_arbiter #(
    parameter int SIDE_MAX = 16,
    parameter int DATA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblnk,
    input  logic              new_game,
    input  logic [2:0]        board_size,
    input  logic              a_valid,
    input  logic [3:0]        a_row,
    input  logic [3:0]        a_col,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [3:0]        b_row,
    input  logic [3:0]        b_col,
    input  logic [DATA_W-1:0] b_data,
    output logic              a_ready,
    output logic              a_err,
    output logic              b_ready,
    output logic              b_err,
    output logic              wr_en,
    output logic [3:0]        wr_row,
    output logic [3:0]        wr_col,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);
    localparam int CELLS = SIDE_MAX * SIDE_MAX;
    localparam int CNT_W = $clog2(CELLS);
    localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(CELLS - 1);
    localparam logic [CNT_W-1:0] SIDE_C    = CNT_W'(SIDE_MAX);

    typedef enum logic [1:0] {IDLE, CLEAR, WRITE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last_a;

    logic               grant_b;
    logic [3:0]         sel_row, sel_col;
    logic [DATA_W-1:0]  sel_data;
    logic [5:0]         side;
    logic               legal, in_range;
    logic [CNT_W-1:0]   nxt_cnt;

    always_comb begin
        // On a tie the side that did not win last time gets the grant.
        grant_b  = b_valid && (!a_valid || last_a);
        sel_row  = grant_b ? b_row  : a_row;
        sel_col  = grant_b ? b_col  : a_col;
        sel_data = grant_b ? b_data : a_data;
        side     = {3'b000, board_size} * {3'b000, board_size};
        legal    = (board_size >= 3'd2) && (board_size <= 3'd4);
        in_range = legal && ({2'b00, sel_row} < side) && ({2'b00, sel_col} < side);
        nxt_cnt  = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last_a  <= 1'b0;
            wr_en   <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
            a_ready <= 1'b0;
            a_err   <= 1'b0;
            b_ready <= 1'b0;
            b_err   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            a_ready <= 1'b0;
            a_err   <= 1'b0;
            b_ready <= 1'b0;
            b_err   <= 1'b0;
            if (new_game) begin
                // Outputs present cell (0,0) in the first CLEAR cycle.
                state   <= CLEAR;
                cnt     <= '0;
                busy    <= 1'b1;
                wr_en   <= 1'b1;
                wr_row  <= '0;
                wr_col  <= '0;
                wr_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (vblnk && (a_valid || b_valid)) begin
                            state   <= WRITE;
                            last_a  <= !grant_b;
                            wr_en   <= in_range;
                            a_ready <= !grant_b;
                            a_err   <= !grant_b && !in_range;
                            b_ready <= grant_b;
                            b_err   <= grant_b && !in_range;
                            if (in_range) begin
                                wr_row  <= sel_row;
                                wr_col  <= sel_col;
                                wr_data <= sel_data;
                            end
                        end
                    end
                    WRITE: state <= IDLE;
                    CLEAR: begin
                        if (cnt == LAST_CELL) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt     <= nxt_cnt;
                            wr_en   <= 1'b1;
                            wr_row  <= 4'(nxt_cnt / SIDE_C);
                            wr_col  <= 4'(nxt_cnt % SIDE_C);
                            wr_data <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
